// File: rtl/m_seq_checker.sv
// PRBS m-sequence checker (x^8+x^6+x^5+x^4+1) with search/verify/lock and windowed loss.
// Define M_SEQ_CHK_STATS_EN to build the err_cnt/bit_cnt statistics counters.
module m_seq_checker #(
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned WIN_LEN  = 64,
  parameter int unsigned LOSS_THR = 8,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_seq,
  input  logic             bit_en,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      bit_cnt
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [7:0] RUN_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0] WIN_LAST = 8'(WIN_LEN - 1);
  localparam logic [7:0] THR      = 8'(LOSS_THR);

  state_t     state;
  state_t     state_nx;
  logic [7:0] r;
  logic [7:0] r_nx;
  logic [3:0] fill;
  logic [3:0] fill_nx;
  logic [7:0] run;
  logic [7:0] run_nx;
  logic [7:0] win_bits;
  logic [7:0] win_bits_nx;
  logic [7:0] win_err;
  logic [7:0] win_err_nx;
  logic [7:0] win_err_inc;
  logic       err_nx;
  logic       pred;
  logic       mism;
  logic [7:0] shift_in;
  logic [7:0] shift_p;

  assign pred        = r[7] ^ r[5] ^ r[4] ^ r[3];
  assign mism        = m_seq ^ pred;
  assign shift_in    = {r[6:0], m_seq};
  assign shift_p     = {r[6:0], pred};
  assign win_err_inc = win_err + {7'd0, mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      r        <= '0;
      fill     <= '0;
      run      <= '0;
      win_bits <= '0;
      win_err  <= '0;
      locked   <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nx;
      r        <= r_nx;
      fill     <= fill_nx;
      run      <= run_nx;
      win_bits <= win_bits_nx;
      win_err  <= win_err_nx;
      locked   <= (state_nx == LOCKED);
      err_flag <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    r_nx        = r;
    fill_nx     = fill;
    run_nx      = run;
    win_bits_nx = win_bits;
    win_err_nx  = win_err;
    err_nx      = 1'b0;
    if (bit_en) begin
      unique case (state)
        SEARCH: begin
          r_nx   = shift_in;
          run_nx = '0;
          if (fill == 4'd7) begin
            // an all-zero history would self-predict zeros forever
            fill_nx = '0;
            if (shift_in != 8'd0) state_nx = VERIFY;
          end else begin
            fill_nx = fill + 4'd1;
          end
        end
        VERIFY: begin
          if (mism) begin
            state_nx = SEARCH;
            fill_nx  = 4'd1;
            run_nx   = '0;
            r_nx     = shift_in;
          end else begin
            r_nx = shift_p;
            if (run == RUN_LAST) begin
              state_nx    = LOCKED;
              run_nx      = '0;
              win_bits_nx = '0;
              win_err_nx  = '0;
            end else begin
              run_nx = run + 8'd1;
            end
          end
        end
        LOCKED: begin
          // flywheel: history never takes the received bit
          r_nx   = shift_p;
          err_nx = mism;
          if (mism && (win_err_inc == THR)) begin
            state_nx    = SEARCH;
            fill_nx     = '0;
            run_nx      = '0;
            win_bits_nx = '0;
            win_err_nx  = '0;
          end else if (win_bits == WIN_LAST) begin
            win_bits_nx = '0;
            win_err_nx  = '0;
          end else begin
            win_bits_nx = win_bits + 8'd1;
            win_err_nx  = win_err_inc;
          end
        end
        default: begin
          state_nx = SEARCH;
        end
      endcase
    end
  end

`ifdef M_SEQ_CHK_STATS_EN
  logic [ERR_W-1:0] err_q;
  logic [31:0]      bits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= '0;
      bits_q <= '0;
    end else if (clr_cnt) begin
      err_q  <= '0;
      bits_q <= '0;
    end else if (bit_en && (state == LOCKED)) begin
      if (bits_q != '1) bits_q <= bits_q + 32'd1;
      if (mism && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
  assign bit_cnt = bits_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign err_cnt    = '0;
  assign bit_cnt    = '0;
`endif

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed bench for m_seq_checker: lock, single error, burst loss, clear, reset, bit_en gaps.
// Expected counter values follow M_SEQ_CHK_STATS_EN (zero when undefined).
module tb_m_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_seq = 1'b0;
  logic        bit_en = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err_flag;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  g = 8'hA5;

`ifdef M_SEQ_CHK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  m_seq_checker #(
    .LOCK_CNT(16),
    .WIN_LEN (64),
    .LOSS_THR(8),
    .ERR_W   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_seq   (m_seq),
    .bit_en  (bit_en),
    .clr_cnt (clr_cnt),
    .locked  (locked),
    .err_flag(err_flag),
    .err_cnt (err_cnt),
    .bit_cnt (bit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  task automatic gen(output logic b);
    b = g[7] ^ g[5] ^ g[4] ^ g[3];
    g = {g[6:0], b};
  endtask

  task automatic drive(input logic b, input logic en);
    @(negedge clk);
    m_seq  = b;
    bit_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      drive(b, 1'b1);
    end
  endtask

  task automatic bad();
    logic b;
    gen(b);
    drive(~b, 1'b1);
  endtask

  initial begin
    logic b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    clean(23);
    chk("pre_lock_23", locked, 0);
    clean(1);
    chk("lock_at_24", locked, 1);
    chk("bits_at_lock", bit_cnt, 0);

    clean(10);
    chk("bits_10", bit_cnt, st(10));
    chk("clean_err_cnt", err_cnt, 0);
    chk("clean_err_flag", err_flag, 0);

    bad();
    chk("single_pulse", err_flag, 1);
    chk("single_err_cnt", err_cnt, st(1));
    clean(1);
    chk("pulse_end", err_flag, 0);
    chk("single_locked", locked, 1);
    clean(19);
    chk("single_no_more", err_cnt, st(1));
    chk("single_still_lock", locked, 1);
    chk("bits_31", bit_cnt, st(31));

    clean(33);
    chk("bits_64", bit_cnt, st(64));
    for (int i = 0; i < 7; i++) bad();
    chk("burst7_locked", locked, 1);
    bad();
    chk("burst8_unlock", locked, 0);
    chk("burst_err_cnt", err_cnt, st(9));
    chk("burst_bit_cnt", bit_cnt, st(72));
    clean(23);
    chk("relock_pre_23", locked, 0);
    chk("err_cnt_held", err_cnt, st(9));
    clean(1);
    chk("relock_24", locked, 1);

    gen(b);
    @(negedge clk);
    m_seq   = ~b;
    bit_en  = 1'b1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("clr_err_flag", err_flag, 1);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_bit_cnt", bit_cnt, 0);
    chk("clr_locked", locked, 1);
    clean(1);
    chk("after_clr_bits", bit_cnt, st(1));

    bad();
    chk("pre_rst_flag", err_flag, 1);
    rst_n = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_err_flag", err_flag, 0);
    chk("async_err_cnt", err_cnt, 0);
    chk("async_bit_cnt", bit_cnt, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    bit_en = 1'b0;

    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1);
    chk("zeros_no_lock", locked, 0);

    for (int i = 0; i < 24; i++) begin
      gen(b);
      drive(b, 1'b1);
      if (i == 22) chk("gap_pre_lock", locked, 0);
      drive(~b, 1'b0);
    end
    chk("gap_lock_24", locked, 1);
    chk("gap_bits", bit_cnt, 0);
    bit_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
